// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single-port data memory.
// Optional DMEM_ARB_CLEAR_ON_RESET_EN: zero-fill the memory after reset.
module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic              err0,
   output logic              err1,
   output logic              busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      ACCESS
   } state_t;

   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

`ifdef DMEM_ARB_CLEAR_ON_RESET_EN
   localparam state_t RST_STATE = INIT;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   state_t state;
   state_t state_nxt;

   // prio is the port that wins when both request at once
   logic prio;
   logic win;
   logic take;
   logic in_range;

   logic              a_port;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [ADDR_W-1:0] cnt;

   assign take     = (state == IDLE) && (req0 || req1);
   assign win      = (req0 && req1) ? prio : req1;
   assign in_range = {1'b0, a_addr} < LIMIT;

`ifdef DMEM_ARB_CLEAR_ON_RESET_EN
   assign busy = (state == INIT);
`else
   assign busy = 1'b0;
`endif

   // state register, clear counter, winner latch and round-robin pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RST_STATE;
         cnt     <= '0;
         prio    <= 1'b0;
         a_port  <= 1'b0;
         a_we    <= 1'b0;
         a_addr  <= '0;
         a_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) begin
            cnt <= cnt + ADDR_W'(1);
         end
         if (take) begin
            a_port  <= win;
            a_we    <= win ? we1 : we0;
            a_addr  <= win ? addr1 : addr0;
            a_wdata <= win ? wdata1 : wdata0;
            prio    <= ~win;
         end
      end
   end

   // next state: INIT sweeps once, ACCESS always lasts one cycle
   always_comb begin
      state_nxt = state;
      unique case (state)
         INIT: begin
            if (cnt == LAST) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = RST_STATE;
         end
      endcase
   end

   // grant, error and memory drive; everything forced low while in reset
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (reset) begin
         unique case (state)
            INIT: begin
               mem_we   = 1'b1;
               mem_addr = cnt;
            end
            ACCESS: begin
               gnt0      = ~a_port;
               gnt1      = a_port;
               err0      = ~a_port & ~in_range;
               err1      = a_port & ~in_range;
               mem_we    = a_we & in_range;
               mem_addr  = a_addr;
               mem_wdata = a_wdata;
            end
            default: begin
            end
         endcase
      end
   end

   // load data captured at the end of ACCESS, valid pulses the cycle after
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0  <= '0;
         rdata1  <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (state == ACCESS && !a_we) begin
            if (a_port) begin
               rdata1  <= in_range ? mem_rdata : '0;
               rvalid1 <= 1'b1;
            end else begin
               rdata0  <= in_range ? mem_rdata : '0;
               rvalid0 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model with shadow memory,
// directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 128;
   localparam int IW    = 7;
   localparam logic [AW-1:0] LIM = AW'(DEPTH);
`ifdef DMEM_ARB_CLEAR_ON_RESET_EN
   localparam int INIT_CYC = DEPTH;
`else
   localparam int INIT_CYC = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req0 = 1'b0;
   logic req1 = 1'b0;
   logic we0 = 1'b0;
   logic we1 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [AW-1:0] addr1 = '0;
   logic [DW-1:0] wdata0 = '0;
   logic [DW-1:0] wdata1 = '0;
   logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .err0(err0), .err1(err1),
      .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // external memory: unwritten words read a per-address pattern
   logic [DW-1:0] tbmem [DEPTH];
   bit written [DEPTH];

   function automatic logic [DW-1:0] mem_init(input int a);
      return DW'(32'h3C5A ^ (a * 37));
   endfunction

   always @(posedge clk) begin
      if (mem_we && mem_addr < LIM) begin
         tbmem[mem_addr[IW-1:0]]   <= mem_wdata;
         written[mem_addr[IW-1:0]] <= 1'b1;
      end
   end

   assign mem_rdata = (mem_addr < LIM)
      ? (written[mem_addr[IW-1:0]] ? tbmem[mem_addr[IW-1:0]]
                                   : mem_init(int'(mem_addr[IW-1:0])))
      : 16'hDEAD;

   // behavioural model
   int m_init;
   bit m_acc;
   bit m_port;
   bit m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit m_prio;
   bit [1:0] m_rv;
   logic [DW-1:0] m_rd [2];
   logic [DW-1:0] ref_mem [DEPTH];

   int errs = 0;
   int checks = 0;
   bit pend [2];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_init  = INIT_CYC;
      m_acc   = 1'b0;
      m_prio  = 1'b0;
      m_rv    = 2'b00;
      m_rd[0] = '0;
      m_rd[1] = '0;
   endtask

   task automatic model_step();
      bit [1:0] nrv;
      nrv = 2'b00;
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_init > 0) begin
         ref_mem[DEPTH - m_init] = '0;
         m_init--;
      end else if (m_acc) begin
         if (!m_we) begin
            m_rd[m_port] = (m_addr < LIM) ? ref_mem[m_addr[IW-1:0]] : '0;
            nrv[m_port] = 1'b1;
         end else if (m_addr < LIM) begin
            ref_mem[m_addr[IW-1:0]] = m_data;
         end
         m_acc = 1'b0;
      end else if (req0 || req1) begin
         m_port = (req0 && req1) ? m_prio : req1;
         m_we   = m_port ? we1 : we0;
         m_addr = m_port ? addr1 : addr0;
         m_data = m_port ? wdata1 : wdata0;
         m_acc  = 1'b1;
         m_prio = !m_port;
      end
      m_rv = nrv;
   endtask

   task automatic compare_all();
      logic [1:0] eg, ee;
      logic ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      eg = 2'b00;
      ee = 2'b00;
      ewe = 1'b0;
      ea = '0;
      ed = '0;
      if (reset) begin
         if (m_init > 0) begin
            ewe = 1'b1;
            ea  = AW'(DEPTH - m_init);
         end else if (m_acc) begin
            eg[m_port] = 1'b1;
            ee[m_port] = !(m_addr < LIM);
            ewe = m_we && (m_addr < LIM);
            ea  = m_addr;
            ed  = m_data;
         end
      end
      chk("gnt", 32'({gnt1, gnt0}), 32'(eg));
      chk("err", 32'({err1, err0}), 32'(ee));
      chk("rvalid", 32'({rvalid1, rvalid0}), 32'(m_rv));
      chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
      chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
      chk("busy", 32'(busy), 32'(m_init > 0));
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(ed));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_ready();
      while (m_init > 0) tick();
   endtask

   task automatic assert_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
   endtask

   task automatic drive_port(input int p);
      logic g, nwe;
      logic [AW-1:0] na;
      logic [DW-1:0] nd;
      bit fresh;
      g = (p == 0) ? gnt0 : gnt1;
      fresh = 1'b0;
      if (pend[p] && (g || $urandom_range(0, 19) == 0)) pend[p] = 1'b0;
      if (!pend[p] && $urandom_range(0, 2) == 0) begin
         pend[p] = 1'b1;
         fresh = 1'b1;
      end
      if (!pend[p] || fresh) begin
         nwe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) na = AW'($urandom);
         else na = AW'($urandom_range(0, DEPTH + 40));
         nd = DW'($urandom);
         if (p == 0) begin
            we0 = nwe; addr0 = na; wdata0 = nd;
         end else begin
            we1 = nwe; addr1 = na; wdata1 = nd;
         end
      end
      if (p == 0) req0 = pend[p];
      else req1 = pend[p];
   endtask

   initial begin
      logic [1:0] exp_g [8];
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem_init(i);
      model_reset();

      // reset state
      @(negedge clk);
      compare_all();
      chk("rst_busy", 32'(busy), 32'(INIT_CYC > 0));
      chk("rst_gnt", 32'({gnt1, gnt0}), 32'h0);
      chk("rst_rdata0", 32'(rdata0), 32'h0);
      tick();

      // release with req1 pending
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'd3;
      reset = 1'b1;
      #1;
      compare_all();
`ifdef DMEM_ARB_CLEAR_ON_RESET_EN
      chk("init_we", 32'(mem_we), 32'h1);
      chk("init_addr", 32'(mem_addr), 32'h0);
      chk("init_busy", 32'(busy), 32'h1);
      @(negedge clk);
      wait_ready();
      chk("init_busy_fall", 32'(busy), 32'h0);
`endif
      tick();
      chk("first_gnt1", 32'({gnt1, gnt0}), 32'h2);
      chk("busy_low", 32'(busy), 32'h0);
      req1 = 1'b0;
      tick();
      chk("first_rvalid1", 32'(rvalid1), 32'h1);

      // store then load on port 0
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'd5; wdata0 = 16'hBEEF;
      tick();
      chk("st_gnt0", 32'(gnt0), 32'h1);
      chk("st_we", 32'(mem_we), 32'h1);
      chk("st_addr", 32'(mem_addr), 32'd5);
      req0 = 1'b0;
      tick();
      req0 = 1'b1; we0 = 1'b0;
      tick();
      req0 = 1'b0;
      tick();
      chk("ld_rvalid0", 32'(rvalid0), 32'h1);
      chk("ld_rdata0", 32'(rdata0), 32'hBEEF);

      // out-of-range on port 1
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'd200; wdata1 = 16'h1234;
      tick();
      chk("oor_err1", 32'(err1), 32'h1);
      chk("oor_we", 32'(mem_we), 32'h0);
      req1 = 1'b0;
      tick();
      req1 = 1'b1; we1 = 1'b0;
      tick();
      req1 = 1'b0;
      tick();
      chk("oor_rvalid1", 32'(rvalid1), 32'h1);
      chk("oor_rdata1", 32'(rdata1), 32'h0);

      // contention straight after reset
      assert_reset();
      tick();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
      reset = 1'b1;
      wait_ready();
      exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("rr_%0d", i), 32'({gnt1, gnt0}), 32'(exp_g[i]));
      end

      // reset in the middle of a port 0 load
      req1 = 1'b0; addr0 = 16'd5;
      tick();
      chk("mid_gnt0", 32'(gnt0), 32'h1);
      assert_reset();
      chk("mid_rst_gnt0", 32'(gnt0), 32'h0);
      tick();
      chk("mid_no_rvalid0", 32'(rvalid0), 32'h0);
      req1 = 1'b1; addr1 = 16'd9;
      reset = 1'b1;
      wait_ready();
      tick();
      chk("rr_restart", 32'({gnt1, gnt0}), 32'h1);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // random traffic
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         if ($urandom_range(0, 599) == 0) begin
            assert_reset();
            tick();
            tick();
            reset = 1'b1;
         end
         drive_port(0);
         drive_port(1);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the requester and memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, the data word width.
REQ-003 The block SHALL have parameter DEPTH, default 128, the number of valid memory words.
REQ-004 The block SHALL have the following ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- req0 / req1  input  1  access request, port 0 (CPU) / port 1 (DMA).
- we0 / we1  input  1  1 = store, 0 = load.
- addr0 / addr1  input  ADDR_W  word address.
- wdata0 / wdata1  input  DATA_W  store data.
- gnt0 / gnt1  output  1  one-cycle grant pulse.
- rdata0 / rdata1  output  DATA_W  load data.
- rvalid0 / rvalid1  output  1  load-data-valid pulse.
- err0 / err1  output  1  out-of-range access pulse.
- busy  output  1  initialisation in progress.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory combinational read data.

Function
REQ-005 The block SHALL implement states INIT, IDLE and ACCESS.
REQ-006 In IDLE, on a rising edge with at least one req asserted, the block SHALL latch the winner's we, addr and wdata and enter ACCESS.
REQ-007 Arbitration SHALL be round-robin: when both requests are asserted, the port not granted most recently wins; after reset, port 0 wins.
REQ-008 In ACCESS (exactly one cycle), the block SHALL assert gnt of the winning port, drive mem_addr and mem_wdata from the latched values, and assert mem_we only for an in-range store.
REQ-009 An access with addr >= DEPTH SHALL be out-of-range: mem_we stays 0, err of that port pulses in the ACCESS cycle, and a load returns 0.
REQ-010 At the end of the ACCESS cycle, a load SHALL register mem_rdata (or 0 if out-of-range) into the winner's rdata, and the winner's rvalid SHALL pulse one cycle later; stores SHALL produce no rvalid.
REQ-011 rdata SHALL hold its value until the next load on the same port.
REQ-012 ACCESS SHALL always return to IDLE, giving a peak throughput of one access per 2 cycles.
REQ-013 A requester SHALL hold req, we, addr and wdata stable until its gnt; req deasserted before grant SHALL simply withdraw the request.
REQ-014 A req held after gnt SHALL be treated as a new request in the following IDLE cycle.
REQ-015 At most one gnt, rvalid or err per port, and at most one gnt in total, SHALL be high in any cycle.
REQ-016 When idle with no request, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.

Reset
REQ-017 While reset is low, all outputs SHALL be 0, except busy, which SHALL be 1 when DMEM_ARB_CLEAR_ON_RESET_EN is defined.
REQ-018 While reset is low, the round-robin pointer SHALL select port 0.
REQ-019 Reset asserted mid-ACCESS or mid-INIT SHALL abort the operation with no further memory write, and SHALL restart from the initial state on release.

Configuration
REQ-020 With DMEM_ARB_CLEAR_ON_RESET_EN defined, the state after reset SHALL be INIT.
- INIT writes 0 to addresses 0..DEPTH-1, one per cycle, with mem_we = 1.
- busy = 1 and no gnt is issued during INIT.
- After the write to address DEPTH-1, busy falls and the state moves to IDLE.
- INIT takes DEPTH cycles; requests are held pending until it completes.
REQ-021 Without DMEM_ARB_CLEAR_ON_RESET_EN, the state after reset SHALL be IDLE, busy SHALL be constant 0, and no clearing writes SHALL occur.

Verification
REQ-022 Init (macro on): release reset -> mem_we high for 128 cycles with mem_addr 0..127 and mem_wdata 0, busy falls after the write to 127, no gnt during that time.
REQ-023 Single store then load: req0, we0=1, addr0=5, wdata0=16'hBEEF -> gnt0 with mem_we=1 and mem_addr=5; then a load from 5 -> rvalid0 and rdata0=16'hBEEF two cycles after the request was sampled.
REQ-024 Contention: req0 and req1 held continuously after reset -> grants alternate gnt0, gnt1, gnt0, gnt1, one every 2 cycles.
REQ-025 Out-of-range: port 1 stores to addr 16'd200 -> err1 pulses, mem_we stays 0; a load from 200 -> rdata1=0 with rvalid1.
REQ-026 Reset mid-access: reset asserted during a port 0 ACCESS cycle -> outputs go to 0 immediately, no rvalid0 follows, and arbitration restarts with port 0 priority.
REQ-027 Macro off: release reset with req1 asserted -> gnt1 one cycle after the first sampled edge, and busy remains 0.
